wb_dbus_if: RTL and testbench
=============================

WB_DBUS_IF -- requirements
Module: wb_dbus_if

Interface
REQ-001 SHALL have parameter: TIMEOUT, 255, bus cycles in BUSY without ack before abort (1..1023).
REQ-002 SHALL have port: clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port: rst  input  1  reset; synchronous, active-low.
REQ-004 SHALL have ports: cpu_ce_i  input  1  memory request valid; cpu_we_i  input  1  1=store; cpu_addr_i  input  32  byte address; cpu_data_i  input  32  store data; cpu_sel_i  input  4  byte enables.
REQ-005 SHALL have port: cpu_data_o  output  32  load data returned to the mem stage.
REQ-006 SHALL have ports: stall_i  input  6  pipeline stall vector from ctrl; flush_i  input  1  pipeline flush.
REQ-007 SHALL have port: stallreq_o  output  1  stall request to ctrl.
REQ-008 SHALL have ports: wishbone_data_i  input  32  read data; wishbone_ack_i  input  1  slave ack.
REQ-009 SHALL have ports: wishbone_addr_o  output  32; wishbone_data_o  output  32; wishbone_we_o  output  1; wishbone_sel_o  output  4; wishbone_stb_o  output  1; wishbone_cyc_o  output  1 (all registered).
REQ-010 SHALL have port: bus_err_o  output  1  one-cycle pulse on timeout abort.

Function
REQ-011 SHALL implement FSM states IDLE, BUSY, WAIT_FOR_STALL.
REQ-012 IDLE, cpu_ce_i=1, flush_i=0: next edge register addr/data/we/sel, set stb=cyc=1, clear timeout counter, go BUSY.
REQ-013 IDLE: stallreq_o = cpu_ce_i & ~flush_i (combinational); cpu_data_o=0.
REQ-014 BUSY, ack=0, flush_i=0: stallreq_o=1, bus outputs held stable, counter increments.
REQ-015 BUSY, ack=1: stallreq_o=0 same cycle; cpu_data_o=wishbone_data_i if we=0, else 0; next edge stb=cyc=we=0, addr/data/sel=0, rd_buf<=wishbone_data_i (0 for store).
REQ-016 BUSY after ack: next state WAIT_FOR_STALL if stall_i!=0, else IDLE.
REQ-017 WAIT_FOR_STALL: stallreq_o=0, cpu_data_o=rd_buf, no new bus cycle; go IDLE when stall_i==0.
REQ-018 BUSY, flush_i=1: flush has priority over ack; next edge drop stb/cyc, clear outputs, rd_buf<=0, go IDLE; stallreq_o=0 that cycle.
REQ-019 BUSY, counter reaches TIMEOUT without ack: stallreq_o=0 that cycle, cpu_data_o=0, bus_err_o=1 for exactly that cycle; next edge drop stb/cyc, rd_buf<=0, transition per REQ-016.
REQ-020 Ack arriving in IDLE or WAIT_FOR_STALL SHALL be ignored.
REQ-021 Only one outstanding Wishbone cycle; stb and cyc SHALL always be equal.
REQ-022 Minimum transaction latency: request seen in cycle N, stb asserted N+1, zero-wait ack N+1, stallreq_o low N+1.
REQ-023 Counter SHALL saturate, never wrap; width ceil(log2(TIMEOUT+1)).

Reset
REQ-024 rst=0 at clock edge: state=IDLE, all wishbone_*_o=0, rd_buf=0, counter=0, bus_err_o=0.
REQ-025 Reset mid-BUSY SHALL abandon the cycle immediately (stb/cyc low next edge), no bus_err_o pulse.
REQ-026 Combinational outputs SHALL read 0 while rst=0.

Verification
REQ-027 Load: ce=1,we=0,addr=0x0000_0100,sel=F; slave acks 2 cycles after stb with 0xDEADBEEF -> stallreq high 3 cycles, cpu_data_o=0xDEADBEEF in ack cycle, stb low next edge.
REQ-028 Store: ce=1,we=1,addr=0x8,data=0x1234_5678,sel=0011 -> wishbone_we_o=1, data/sel match, cpu_data_o=0 on ack.
REQ-029 Stall hold: load acks 0xCAFEF00D while stall_i=000011 for 3 cycles -> WAIT_FOR_STALL, cpu_data_o=0xCAFEF00D all 3 cycles, stallreq_o=0, no new stb.
REQ-030 Flush: flush_i=1 in second BUSY cycle with simultaneous ack -> stallreq_o=0, stb/cyc low next edge, IDLE, rd_buf=0.
REQ-031 Timeout: TIMEOUT=4, no ack -> bus_err_o single pulse at 4th BUSY cycle, cpu_data_o=0, stb low next edge.
REQ-032 Reset: rst=0 during BUSY -> all outputs 0 next edge, later request starts cleanly.

Source files
------------

// File: rtl/wb_dbus_if.sv
// -----------------------------------------------------------------------------
// wb_dbus_if
// Data-side bridge between a pipelined CPU memory stage and a classic
// single-outstanding Wishbone master. A request seen in IDLE is registered
// onto the bus on the next edge, and the pipeline is stalled until the
// slave acks, the cycle is flushed, or the timeout watchdog aborts it. If
// the pipeline is still stalled by someone else when the access finishes,
// the load data is parked in rd_buf and replayed until the stall clears.
//
// Ports
//   clk, rst            clock; synchronous active-low reset
//   cpu_ce_i/we/addr/data/sel   memory request from the mem stage
//   cpu_data_o          load data back to the mem stage (combinational)
//   stall_i, flush_i    pipeline stall vector / flush from ctrl
//   stallreq_o          stall request to ctrl (combinational)
//   wishbone_*_i        slave read data and ack
//   wishbone_*_o        registered master outputs (stb == cyc)
//   bus_err_o           one-cycle pulse in the cycle a timeout aborts
// -----------------------------------------------------------------------------
module wb_dbus_if #(
  parameter int TIMEOUT = 255  // BUSY cycles without ack before abort, 1..1023
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_ce_i,
  input  logic        cpu_we_i,
  input  logic [31:0] cpu_addr_i,
  input  logic [31:0] cpu_data_i,
  input  logic [3:0]  cpu_sel_i,
  output logic [31:0] cpu_data_o,
  input  logic [5:0]  stall_i,
  input  logic        flush_i,
  output logic        stallreq_o,
  input  logic [31:0] wishbone_data_i,
  input  logic        wishbone_ack_i,
  output logic [31:0] wishbone_addr_o,
  output logic [31:0] wishbone_data_o,
  output logic        wishbone_we_o,
  output logic [3:0]  wishbone_sel_o,
  output logic        wishbone_stb_o,
  output logic        wishbone_cyc_o,
  output logic        bus_err_o
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  localparam logic [1:0] S_IDLE           = 2'd0;
  localparam logic [1:0] S_BUSY           = 2'd1;
  localparam logic [1:0] S_WAIT_FOR_STALL = 2'd2;

  // cnt_q counts BUSY cycles already spent without ack, so the cycle in
  // which cnt_q == TIMEOUT-1 is the TIMEOUT-th one: that is where we abort.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);

  logic [1:0]       state_q,  state_d;
  logic [31:0]      addr_q,   addr_d;
  logic [31:0]      data_q,   data_d;
  logic             we_q,     we_d;
  logic [3:0]       sel_q,    sel_d;
  logic             cyc_q,    cyc_d;
  logic [31:0]      rd_buf_q, rd_buf_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;

  logic        stallreq_c;
  logic [31:0] cpu_data_c;
  logic        bus_err_c;
  logic        stall_any;

  assign stall_any = |stall_i;

  // NOTE: every signal assigned here gets a default first; a path that
  // forgets one would otherwise infer a latch.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    data_d     = data_q;
    we_d       = we_q;
    sel_d      = sel_q;
    cyc_d      = cyc_q;
    rd_buf_d   = rd_buf_q;
    cnt_d      = cnt_q;
    stallreq_c = 1'b0;
    cpu_data_c = 32'h0;
    bus_err_c  = 1'b0;

    case (state_q)
      S_IDLE: begin
        stallreq_c = cpu_ce_i & ~flush_i;
        if (cpu_ce_i && !flush_i) begin
          addr_d  = cpu_addr_i;
          data_d  = cpu_data_i;
          we_d    = cpu_we_i;
          sel_d   = cpu_sel_i;
          cyc_d   = 1'b1;
          cnt_d   = '0;
          state_d = S_BUSY;
        end
      end

      S_BUSY: begin
        // Any way out of BUSY releases the bus and zeroes the address/data
        // lines; only the load-with-ack path leaves real data in rd_buf.
        if (flush_i || wishbone_ack_i || cnt_q >= CNT_LAST) begin
          addr_d = 32'h0;
          data_d = 32'h0;
          we_d   = 1'b0;
          sel_d  = 4'h0;
          cyc_d  = 1'b0;
        end

        if (flush_i) begin
          // Flush wins over a simultaneous ack: the result is discarded.
          rd_buf_d = 32'h0;
          state_d  = S_IDLE;
        end else if (wishbone_ack_i) begin
          cpu_data_c = we_q ? 32'h0 : wishbone_data_i;
          rd_buf_d   = cpu_data_c;
          state_d    = stall_any ? S_WAIT_FOR_STALL : S_IDLE;
        end else if (cnt_q >= CNT_LAST) begin
          bus_err_c = 1'b1;
          rd_buf_d  = 32'h0;
          state_d   = stall_any ? S_WAIT_FOR_STALL : S_IDLE;
        end else begin
          stallreq_c = 1'b1;
          if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      S_WAIT_FOR_STALL: begin
        cpu_data_c = rd_buf_q;
        if (!stall_any) begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments only, and the
  // synchronous reset clears every flop because all of it is control or
  // bus-visible state (there is no storage array here to leave unreset).
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      addr_q   <= 32'h0;
      data_q   <= 32'h0;
      we_q     <= 1'b0;
      sel_q    <= 4'h0;
      cyc_q    <= 1'b0;
      rd_buf_q <= 32'h0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      we_q     <= we_d;
      sel_q    <= sel_d;
      cyc_q    <= cyc_d;
      rd_buf_q <= rd_buf_d;
      cnt_q    <= cnt_d;
    end
  end

  // Combinational outputs are forced low while reset is asserted so a
  // reset landing mid-transfer never produces a stall or an error pulse.
  assign stallreq_o = rst & stallreq_c;
  assign cpu_data_o = rst ? cpu_data_c : 32'h0;
  assign bus_err_o  = rst & bus_err_c;

  assign wishbone_addr_o = addr_q;
  assign wishbone_data_o = data_q;
  assign wishbone_we_o   = we_q;
  assign wishbone_sel_o  = sel_q;
  assign wishbone_stb_o  = cyc_q;
  assign wishbone_cyc_o  = cyc_q;

endmodule

// File: tb/tb_wb_dbus_if.sv
// -----------------------------------------------------------------------------
// tb_wb_dbus_if
// Self-checking bench for wb_dbus_if built with TIMEOUT=4. Each access is
// described at transaction level (ack delay, flush slot, stall-hold length)
// and the expected cycle-by-cycle outputs are derived from those numbers.
// -----------------------------------------------------------------------------
module tb_wb_dbus_if;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_ce_i;
  logic        cpu_we_i;
  logic [31:0] cpu_addr_i;
  logic [31:0] cpu_data_i;
  logic [3:0]  cpu_sel_i;
  logic [31:0] cpu_data_o;
  logic [5:0]  stall_i;
  logic        flush_i;
  logic        stallreq_o;
  logic [31:0] wishbone_data_i;
  logic        wishbone_ack_i;
  logic [31:0] wishbone_addr_o;
  logic [31:0] wishbone_data_o;
  logic        wishbone_we_o;
  logic [3:0]  wishbone_sel_o;
  logic        wishbone_stb_o;
  logic        wishbone_cyc_o;
  logic        bus_err_o;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  wb_dbus_if #(.TIMEOUT(TO)) dut (
    .clk             (clk),
    .rst             (rst),
    .cpu_ce_i        (cpu_ce_i),
    .cpu_we_i        (cpu_we_i),
    .cpu_addr_i      (cpu_addr_i),
    .cpu_data_i      (cpu_data_i),
    .cpu_sel_i       (cpu_sel_i),
    .cpu_data_o      (cpu_data_o),
    .stall_i         (stall_i),
    .flush_i         (flush_i),
    .stallreq_o      (stallreq_o),
    .wishbone_data_i (wishbone_data_i),
    .wishbone_ack_i  (wishbone_ack_i),
    .wishbone_addr_o (wishbone_addr_o),
    .wishbone_data_o (wishbone_data_o),
    .wishbone_we_o   (wishbone_we_o),
    .wishbone_sel_o  (wishbone_sel_o),
    .wishbone_stb_o  (wishbone_stb_o),
    .wishbone_cyc_o  (wishbone_cyc_o),
    .bus_err_o       (bus_err_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; inputs are then changed at +1,
  // and outputs are sampled at +4, well away from either edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  task automatic chk_bus_clear(input string pre);
    chk({pre, ".stb"},  32'(wishbone_stb_o),  32'h0);
    chk({pre, ".cyc"},  32'(wishbone_cyc_o),  32'h0);
    chk({pre, ".we"},   32'(wishbone_we_o),   32'h0);
    chk({pre, ".sel"},  32'(wishbone_sel_o),  32'h0);
    chk({pre, ".addr"}, wishbone_addr_o,      32'h0);
    chk({pre, ".data"}, wishbone_data_o,      32'h0);
  endtask

  task automatic chk_comb(input string pre, input logic sr, input logic [31:0] cd, input logic err);
    chk({pre, ".stallreq"}, 32'(stallreq_o), 32'(sr));
    chk({pre, ".cpu_data"}, cpu_data_o,      cd);
    chk({pre, ".bus_err"},  32'(bus_err_o),  32'(err));
  endtask

  // One access. d: BUSY cycle index carrying the ack (>= TO means never);
  // h: cycles stall_i stays nonzero counting from the completion cycle;
  // f: BUSY cycle index carrying flush_i (-1 for none).
  task automatic run_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] sel, input logic [31:0] rdata,
                         input int d, input int h, input int f);
    logic        ended;
    logic        is_f, is_a, is_t;
    logic [31:0] rd;
    int          wfs;
    ended = 1'b0;
    rd    = 32'h0;
    wfs   = 0;

    // Request cycle in IDLE; a stray ack here must be ignored.
    cpu_ce_i        = 1'b1;
    cpu_we_i        = we;
    cpu_addr_i      = addr;
    cpu_data_i      = wdata;
    cpu_sel_i       = sel;
    flush_i         = 1'b0;
    stall_i         = 6'h0;
    wishbone_ack_i  = 1'($urandom_range(0, 1));
    wishbone_data_i = $urandom;
    settle();
    chk_comb("req", 1'b1, 32'h0, 1'b0);
    chk_bus_clear("req");
    tick();

    for (int k = 0; !ended; k++) begin
      is_f  = (k == f);
      is_a  = (k == d);
      is_t  = (k == TO - 1);
      ended = is_f || is_a || is_t;
      // The CPU side changes freely; the bus must keep the captured request.
      cpu_we_i        = 1'($urandom);
      cpu_addr_i      = $urandom;
      cpu_data_i      = $urandom;
      cpu_sel_i       = 4'($urandom);
      wishbone_ack_i  = is_a;
      wishbone_data_i = is_a ? rdata : $urandom;
      flush_i         = is_f;
      stall_i         = ended ? ((h > 0) ? 6'b000011 : 6'h0) : 6'($urandom_range(0, 63));
      settle();
      chk("busy.stb",  32'(wishbone_stb_o), 32'h1);
      chk("busy.cyc",  32'(wishbone_cyc_o), 32'h1);
      chk("busy.we",   32'(wishbone_we_o),  32'(we));
      chk("busy.sel",  32'(wishbone_sel_o), 32'(sel));
      chk("busy.addr", wishbone_addr_o,     addr);
      chk("busy.data", wishbone_data_o,     wdata);
      if (is_f) begin
        chk_comb("flush", 1'b0, 32'h0, 1'b0);
        rd  = 32'h0;
        wfs = 0;
      end else if (is_a) begin
        rd  = we ? 32'h0 : rdata;
        wfs = h;
        chk_comb("ack", 1'b0, rd, 1'b0);
      end else if (is_t) begin
        chk_comb("timeout", 1'b0, 32'h0, 1'b1);
        rd  = 32'h0;
        wfs = h;
      end else begin
        chk_comb("wait", 1'b1, 32'h0, 1'b0);
      end
      tick();
    end

    // Parked result replayed while the pipeline stays stalled; late acks
    // and a held request must not start anything.
    for (int j = 0; j < wfs; j++) begin
      cpu_ce_i        = 1'b1;
      flush_i         = 1'b0;
      wishbone_ack_i  = 1'($urandom_range(0, 1));
      wishbone_data_i = $urandom;
      stall_i         = (j < wfs - 1) ? 6'($urandom_range(1, 63)) : 6'h0;
      settle();
      chk_comb("hold", 1'b0, rd, 1'b0);
      chk_bus_clear("hold");
      tick();
    end
    cpu_ce_i       = 1'b0;
    wishbone_ack_i = 1'b0;
    stall_i        = 6'h0;
  endtask

  initial begin
    // Reset with a request pending: everything must read zero.
    rst             = 1'b0;
    cpu_ce_i        = 1'b1;
    cpu_we_i        = 1'b1;
    cpu_addr_i      = 32'h0000_0040;
    cpu_data_i      = 32'hFFFF_FFFF;
    cpu_sel_i       = 4'hF;
    stall_i         = 6'h0;
    flush_i         = 1'b0;
    wishbone_data_i = 32'h5555_AAAA;
    wishbone_ack_i  = 1'b1;
    tick();
    tick();
    settle();
    chk_comb("rst", 1'b0, 32'h0, 1'b0);
    chk_bus_clear("rst");
    rst            = 1'b1;
    cpu_ce_i       = 1'b0;
    wishbone_ack_i = 1'b0;
    tick();

    // Load, ack two cycles after stb.
    run_txn(1'b0, 32'h0000_0100, 32'h0, 4'hF, 32'hDEAD_BEEF, 2, 0, -1);
    // Store, zero-wait ack.
    run_txn(1'b1, 32'h0000_0008, 32'h1234_5678, 4'b0011, 32'h9999_9999, 0, 0, -1);
    // Load completing under a three-cycle stall.
    run_txn(1'b0, 32'h0000_0200, 32'h0, 4'hF, 32'hCAFE_F00D, 1, 3, -1);
    // Flush in the second BUSY cycle together with ack.
    run_txn(1'b0, 32'h0000_0300, 32'h0, 4'hF, 32'h1111_2222, 1, 2, 1);
    // Timeouts, with and without the pipeline stalled afterwards.
    run_txn(1'b0, 32'h0000_0400, 32'h0, 4'hF, 32'h3333_4444, 99, 0, -1);
    run_txn(1'b0, 32'h0000_0404, 32'h0, 4'hF, 32'h5555_6666, 99, 2, -1);
    // Ack exactly in the last allowed cycle beats the timeout.
    run_txn(1'b0, 32'h0000_0408, 32'h0, 4'hC, 32'h7777_8888, TO - 1, 0, -1);

    // Flush while a request is presented in IDLE: no stall, no bus cycle.
    cpu_ce_i = 1'b1;
    flush_i  = 1'b1;
    settle();
    chk_comb("idleflush", 1'b0, 32'h0, 1'b0);
    tick();
    cpu_ce_i = 1'b0;
    flush_i  = 1'b0;
    settle();
    chk_bus_clear("idleflush");
    tick();

    // Reset in the BUSY cycle that would otherwise time out.
    cpu_ce_i   = 1'b1;
    cpu_we_i   = 1'b0;
    cpu_addr_i = 32'h0000_0500;
    cpu_sel_i  = 4'hF;
    tick();
    for (int k = 0; k < TO - 1; k++) begin
      settle();
      chk("rstbusy.stb", 32'(wishbone_stb_o), 32'h1);
      tick();
    end
    rst             = 1'b0;
    wishbone_ack_i  = 1'b1;
    wishbone_data_i = 32'hBAD0_BAD0;
    settle();
    chk_comb("rstbusy", 1'b0, 32'h0, 1'b0);
    tick();
    rst            = 1'b1;
    cpu_ce_i       = 1'b0;
    wishbone_ack_i = 1'b0;
    settle();
    chk_comb("postrst", 1'b0, 32'h0, 1'b0);
    chk_bus_clear("postrst");
    tick();
    run_txn(1'b0, 32'h0000_0600, 32'h0, 4'hF, 32'h0BAD_F00D, 1, 0, -1);

    // Randomised accesses, including timeouts and flushes.
    for (int n = 0; n < 40; n++) begin
      int d, h, f;
      d = int'($urandom_range(0, 5));
      h = int'($urandom_range(0, 3));
      f = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 4)) : -1;
      run_txn(1'($urandom), $urandom, $urandom, 4'($urandom), $urandom, d, h, f);
    end

    settle();
    chk_comb("end", 1'b0, 32'h0, 1'b0);
    chk_bus_clear("end");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
